cv32e40s_data_obi_responder: RTL and testbench

OBI data-side responder (subordinate) with Xsecure integrity; the far end of the core's data OBI master. It accepts A-channel transfers and checks reqpar and achk. It drives gnt/gntpar, performs the access on a 1-cycle-latency SRAM port, and returns R-channel responses with rvalidpar and rchk in order. It serves as the TB/system memory model and the on-chip data RAM adapter.

---
 rtl/cv32e40s_pkg.sv | 50 +++++
 rtl/cv32e40s_obi_resp_fifo.sv | 59 +++++
 rtl/cv32e40s_data_obi_responder.sv | 133 +++++++++++++
 tb/tb_cv32e40s_data_obi_responder.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40s_pkg.sv
// Shared OBI data-side integrity definitions, used by both the master and responder sides.
package cv32e40s_pkg;

  localparam int unsigned OBI_DATA_ACHK_W = 12;
  localparam int unsigned OBI_DATA_RCHK_W = 5;

  // A-channel fields covered by the address-phase checksum
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  prot;
    logic [1:0]  memtype;
    logic        dbg;
  } obi_data_req_t;

  // R-channel entry as queued between SRAM and the response port
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_data_resp_t;

  function automatic logic [OBI_DATA_ACHK_W-1:0] calc_data_achk(input obi_data_req_t req);
    logic [OBI_DATA_ACHK_W-1:0] achk;
    achk = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      achk[8+i] = ^req.wdata[8*i +: 8];
      achk[i]   = ^req.addr[8*i +: 8];
    end
    achk[7] = ^6'b0;
    achk[6] = ~^req.dbg;
    achk[5] = ~^{req.be, req.we};
    achk[4] = ~^{req.prot, req.memtype};
    return achk;
  endfunction

  // exokay is not supported on the data port and contributes a constant 0
  function automatic logic [OBI_DATA_RCHK_W-1:0] calc_data_rchk(input logic [31:0] rdata,
                                                               input logic        err);
    logic [OBI_DATA_RCHK_W-1:0] rchk;
    rchk = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      rchk[i] = ^rdata[8*i +: 8];
    end
    rchk[4] = ^{err, 1'b0};
    return rchk;
  endfunction

endpackage

// File: rtl/cv32e40s_obi_resp_fifo.sv
// Small circular response FIFO with occupancy count; depth need not be a power of two.
module cv32e40s_obi_resp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = logic,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  T                 push_data,
  input  logic             pop,
  output T                 head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  T                 storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr] <= push_data;
  end

  // Status and head view
  always_comb begin
    head_data = storage[rd_ptr];
    full      = (cnt == CNT_W'(DEPTH));
    empty     = (cnt == '0);
    count     = cnt;
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/cv32e40s_data_obi_responder.sv
// OBI data responder with Xsecure integrity checks in front of a 1-cycle-latency SRAM port.
module cv32e40s_data_obi_responder
  import cv32e40s_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned MEM_WORDS       = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         obi_req_i,
  input  logic                         obi_reqpar_i,
  output logic                         obi_gnt_o,
  output logic                         obi_gntpar_o,
  input  logic [31:0]                  obi_addr_i,
  input  logic                         obi_we_i,
  input  logic [3:0]                   obi_be_i,
  input  logic [31:0]                  obi_wdata_i,
  input  logic [2:0]                   obi_prot_i,
  input  logic [1:0]                   obi_memtype_i,
  input  logic                         obi_dbg_i,
  input  logic [OBI_DATA_ACHK_W-1:0]   obi_achk_i,
  output logic                         obi_rvalid_o,
  output logic                         obi_rvalidpar_o,
  output logic [31:0]                  obi_rdata_o,
  output logic                         obi_err_o,
  output logic [OBI_DATA_RCHK_W-1:0]   obi_rchk_o,
  input  logic                         resp_hold_i,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
  output logic [3:0]                   mem_be_o,
  output logic [31:0]                  mem_wdata_o,
  input  logic [31:0]                  mem_rdata_i,
  output logic                         achk_err_o,
  output logic                         reqpar_err_o
);

  localparam int unsigned MEM_AW     = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

  obi_data_req_t  a_req;
  logic           accept;
  logic           achk_mismatch;
  logic           addr_oor;
  logic           acc_err;

  logic           pipe_valid;
  logic           pipe_we;
  logic           pipe_err;

  obi_data_resp_t push_data;
  obi_data_resp_t head_data;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] count;

  // A-channel checks, grant and SRAM strobe
  always_comb begin
    a_req         = '{addr: obi_addr_i, we: obi_we_i, be: obi_be_i, wdata: obi_wdata_i,
                      prot: obi_prot_i, memtype: obi_memtype_i, dbg: obi_dbg_i};
    count         = CNT_W'(pipe_valid) + fifo_count;
    obi_gnt_o     = (count < CNT_W'(MAX_OUTSTANDING));
    obi_gntpar_o  = !obi_gnt_o;
    accept        = obi_req_i && obi_gnt_o;
    reqpar_err_o  = (obi_reqpar_i == obi_req_i);
    achk_mismatch = (calc_data_achk(a_req) != obi_achk_i);
    addr_oor      = ({1'b0, obi_addr_i} >= ADDR_LIMIT);
    acc_err       = achk_mismatch || reqpar_err_o || addr_oor;
    mem_req_o     = accept && !acc_err;
    mem_we_o      = obi_we_i;
    mem_addr_o    = obi_addr_i[MEM_AW+1:2];
    mem_be_o      = obi_be_i;
    mem_wdata_o   = obi_wdata_i;
  end

  // Pipe stage tracks the transfer while the SRAM read is in flight; achk error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= 1'b0;
      pipe_we    <= 1'b0;
      pipe_err   <= 1'b0;
      achk_err_o <= 1'b0;
    end else begin
      pipe_valid <= accept;
      achk_err_o <= accept && achk_mismatch;
      if (accept) begin
        pipe_we  <= obi_we_i;
        pipe_err <= acc_err;
      end
    end
  end

  // Errored transfers never touched the SRAM, so their read data is forced to zero
  always_comb begin
    push_data       = '0;
    push_data.rdata = (pipe_we || pipe_err) ? '0 : mem_rdata_i;
    push_data.err   = pipe_err;
  end

  cv32e40s_obi_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (obi_data_resp_t),
    .CNT_W (CNT_W)
  ) resp_fifo_i (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_valid),
    .push_data (push_data),
    .pop       (obi_rvalid_o),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // R-channel from FIFO head; idle outputs read as zero
  always_comb begin
    obi_rvalid_o    = !fifo_empty && !resp_hold_i;
    obi_rvalidpar_o = !obi_rvalid_o;
    obi_rdata_o     = obi_rvalid_o ? head_data.rdata : '0;
    obi_err_o       = obi_rvalid_o && head_data.err;
    obi_rchk_o      = calc_data_rchk(obi_rdata_o, obi_err_o);
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
                                  count <= CNT_W'(MAX_OUTSTANDING));
  a_push_room:   assert property (@(posedge clk) disable iff (rst) pipe_valid |-> !fifo_full);
  a_gntpar:      assert property (@(posedge clk) disable iff (rst) obi_gntpar_o == !obi_gnt_o);
  a_rvalid_data: assert property (@(posedge clk) disable iff (rst) obi_rvalid_o |-> !fifo_empty);

endmodule

// File: tb/tb_cv32e40s_data_obi_responder.sv
// Randomized and directed bench for the data OBI responder against a queue-based reference model.
module tb_cv32e40s_data_obi_responder;

  localparam int MAXO = 2;
  localparam int MW   = 1024;

  logic        clk, rst;
  logic        req, reqpar, gnt, gntpar;
  logic [31:0] addr, wdata;
  logic        we, dbg;
  logic [3:0]  be;
  logic [2:0]  prot;
  logic [1:0]  memtype;
  logic [11:0] achk;
  logic        rvalid, rvalidpar, err;
  logic [31:0] rdata;
  logic [4:0]  rchk;
  logic        hold;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        achk_err, reqpar_err;
  logic        tb_clear;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_x;
  logic [31:0] model_mem [MW];
  logic [31:0] sram      [MW];
  logic [31:0] last_rdata;
  logic        last_err;
  logic [4:0]  last_rchk;
  logic        last_acc_err;

  cv32e40s_data_obi_responder #(.MAX_OUTSTANDING(MAXO), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst),
    .obi_req_i(req), .obi_reqpar_i(reqpar), .obi_gnt_o(gnt), .obi_gntpar_o(gntpar),
    .obi_addr_i(addr), .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata),
    .obi_prot_i(prot), .obi_memtype_i(memtype), .obi_dbg_i(dbg), .obi_achk_i(achk),
    .obi_rvalid_o(rvalid), .obi_rvalidpar_o(rvalidpar), .obi_rdata_o(rdata),
    .obi_err_o(err), .obi_rchk_o(rchk), .resp_hold_i(hold),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .achk_err_o(achk_err), .reqpar_err_o(reqpar_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM with one cycle read latency
  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < MW; i++) sram[i] <= '0;
    end else if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= sram[mem_addr];
    end
  end

  function automatic logic [11:0] model_achk(input logic [31:0] a, input logic w,
                                             input logic [3:0] b, input logic [31:0] d,
                                             input logic [2:0] p, input logic [1:0] m,
                                             input logic g);
    logic [11:0] c;
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[8+k] = 1'($countones(d[8*k +: 8]) % 2);
      c[k]   = 1'($countones(a[8*k +: 8]) % 2);
    end
    c[6] = ~g;
    c[5] = ($countones({b, w}) % 2) == 0;
    c[4] = ($countones({p, m}) % 2) == 0;
    return c;
  endfunction

  function automatic logic [4:0] model_rchk(input logic [31:0] d, input logic e);
    logic [4:0] c;
    c = {e, 4'b0};
    for (int k = 0; k < 4; k++) c[k] = 1'($countones(d[8*k +: 8]) % 2);
    return c;
  endfunction

  // Reference model: evaluate the accepted transfer and queue its expected response
  task automatic record_accept();
    exp_t x;
    logic e;
    e = (achk !== model_achk(addr, we, be, wdata, prot, memtype, dbg)) ||
        (reqpar === req) || (addr >= 32'(4 * MW));
    x.err   = e;
    x.rdata = '0;
    if (!e) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model_mem[addr[11:2]][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        x.rdata = model_mem[addr[11:2]];
      end
    end
    exp_q.push_back(x);
    last_acc_err = e;
  endtask

  task automatic set_req(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d, input logic bad_achk, input logic bad_par);
    addr = a; we = w; be = b; wdata = d;
    prot = 3'($urandom); memtype = 2'($urandom); dbg = 1'($urandom);
    achk = model_achk(a, w, b, d, prot, memtype, dbg) ^ {11'b0, bad_achk};
    req = 1'b1;
    reqpar = bad_par;
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] b,
                      input logic [31:0] d);
    bit acc = 0;
    set_req(a, w, b, d, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gnt === 1'b1) begin
        record_accept();
        acc = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (acc) begin
      @(posedge clk); #1;
    end else begin
      checks++; failures++;
      $display("FAIL xfer_grant_timeout addr=%h gnt=%b required=1", a, gnt);
    end
    req = 1'b0; reqpar = 1'b1;
  endtask

  task automatic drain();
    hold = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Response monitor: parity pairs every cycle, in-order data against the model queue
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (gntpar !== !gnt) begin
        failures++; $display("FAIL gntpar got=%b gnt=%b", gntpar, gnt);
      end
      checks++;
      if (rvalidpar !== !rvalid) begin
        failures++; $display("FAIL rvalidpar got=%b rvalid=%b", rvalidpar, rvalid);
      end
      if (rvalid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL unexpected_response rdata=%h err=%b", rdata, err);
        end else begin
          mon_x = exp_q.pop_front();
          if (rdata !== mon_x.rdata || err !== mon_x.err) begin
            failures++;
            $display("FAIL resp_data got=%h/%b required=%h/%b", rdata, err, mon_x.rdata, mon_x.err);
          end
          checks++;
          if (rchk !== model_rchk(mon_x.rdata, mon_x.err)) begin
            failures++;
            $display("FAIL resp_rchk got=%b required=%b", rchk, model_rchk(mon_x.rdata, mon_x.err));
          end
        end
        last_rdata = rdata; last_err = err; last_rchk = rchk;
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({gnt, gntpar, rvalid, rvalidpar, err, achk_err} !== 6'b100100) begin
      failures++; $display("FAIL reset_during got=%b required=100100",
                           {gnt, gntpar, rvalid, rvalidpar, err, achk_err});
    end
    @(posedge clk); #1;
    rst = 1'b0; tb_clear = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt, gntpar, rvalid, rvalidpar, err, mem_req, achk_err} !== 7'b1001000) begin
      failures++; $display("FAIL reset_ctrl got=%b required=1001000",
                           {gnt, gntpar, rvalid, rvalidpar, err, mem_req, achk_err});
    end
    checks++;
    if (rdata !== 32'h0 || rchk !== 5'h0) begin
      failures++; $display("FAIL reset_data got=%h/%b required=0/0", rdata, rchk);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    xfer(32'h10, 1'b1, 4'b0011, 32'hAABBCCDD);
    xfer(32'h10, 1'b0, 4'b1111, 32'h0);
    drain();
    checks++;
    if (last_rdata !== 32'h0000CCDD || last_err !== 1'b0 || last_rchk !== 5'b00000) begin
      failures++; $display("FAIL write_read got=%h/%b/%b required=0000ccdd/0/00000",
                           last_rdata, last_err, last_rchk);
    end
  endtask

  task automatic test_back_to_back();
    xfer(32'h40, 1'b1, 4'hF, 32'h11111111);
    xfer(32'h44, 1'b1, 4'hF, 32'h22222222);
    xfer(32'h48, 1'b1, 4'hF, 32'h33333333);
    drain();
    hold = 1'b1;
    xfer(32'h40, 1'b0, 4'hF, 32'h0);
    xfer(32'h44, 1'b0, 4'hF, 32'h0);
    set_req(32'h48, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 1'b0 || mem_req !== 1'b0 || rvalid !== 1'b0) begin
        failures++; $display("FAIL b2b_full gnt=%b mem_req=%b rvalid=%b required=0/0/0",
                             gnt, mem_req, rvalid);
      end
      @(posedge clk); #1;
    end
    hold = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || gnt !== 1'b0 || rdata !== 32'h11111111) begin
      failures++; $display("FAIL b2b_pop_cycle rvalid=%b gnt=%b rdata=%h required=1/0/11111111",
                           rvalid, gnt, rdata);
    end
    @(posedge clk); #1;
    xfer(32'h48, 1'b0, 4'hF, 32'h0);
    drain();
    checks++;
    if (last_rdata !== 32'h33333333) begin
      failures++; $display("FAIL b2b_last got=%h required=33333333", last_rdata);
    end
  endtask

  task automatic test_achk_err();
    xfer(32'h20, 1'b1, 4'hF, 32'h5A5A1234);
    drain();
    set_req(32'h20, 1'b1, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (gnt !== 1'b1 || mem_req !== 1'b0 || achk_err !== 1'b0) begin
      failures++; $display("FAIL achk_accept gnt=%b mem_req=%b achk_err=%b required=1/0/0",
                           gnt, mem_req, achk_err);
    end
    record_accept();
    @(posedge clk); #1;
    req = 1'b0; reqpar = 1'b1;
    @(negedge clk);
    checks++;
    if (achk_err !== 1'b1) begin
      failures++; $display("FAIL achk_pulse got=%b required=1", achk_err);
    end
    @(negedge clk);
    checks++;
    if (achk_err !== 1'b0) begin
      failures++; $display("FAIL achk_pulse_end got=%b required=0", achk_err);
    end
    @(posedge clk); #1;
    drain();
    checks++;
    if (last_err !== 1'b1 || last_rchk[4] !== 1'b1 || last_rdata !== 32'h0) begin
      failures++; $display("FAIL achk_resp got=%b/%b/%h required=1/1/0",
                           last_err, last_rchk[4], last_rdata);
    end
    xfer(32'h20, 1'b0, 4'hF, 32'h0);
    drain();
    checks++;
    if (last_rdata !== 32'h5A5A1234) begin
      failures++; $display("FAIL achk_no_write got=%h required=5a5a1234", last_rdata);
    end
  endtask

  task automatic test_reqpar();
    set_req(32'h24, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (reqpar_err !== 1'b1 || mem_req !== 1'b0) begin
      failures++; $display("FAIL reqpar_flag got=%b/%b required=1/0", reqpar_err, mem_req);
    end
    record_accept();
    @(posedge clk); #1;
    req = 1'b0; reqpar = 1'b1;
    @(negedge clk);
    checks++;
    if (reqpar_err !== 1'b0) begin
      failures++; $display("FAIL reqpar_idle got=%b required=0", reqpar_err);
    end
    @(posedge clk); #1;
    drain();
    checks++;
    if (last_err !== 1'b1) begin
      failures++; $display("FAIL reqpar_resp got=%b required=1", last_err);
    end
  endtask

  task automatic test_addr_range();
    set_req(32'(4 * MW), 1'b1, 4'hF, 32'h12345678, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (gnt !== 1'b1 || mem_req !== 1'b0) begin
      failures++; $display("FAIL oor_mem_req gnt=%b mem_req=%b required=1/0", gnt, mem_req);
    end
    record_accept();
    @(posedge clk); #1;
    req = 1'b0; reqpar = 1'b1;
    drain();
    checks++;
    if (last_err !== 1'b1 || last_rdata !== 32'h0) begin
      failures++; $display("FAIL oor_resp got=%b/%h required=1/0", last_err, last_rdata);
    end
    xfer(32'(4 * MW - 4), 1'b1, 4'hF, 32'hCAFEF00D);
    xfer(32'(4 * MW - 4), 1'b0, 4'hF, 32'h0);
    drain();
    checks++;
    if (last_err !== 1'b0 || last_rdata !== 32'hCAFEF00D) begin
      failures++; $display("FAIL top_word got=%b/%h required=0/cafef00d", last_err, last_rdata);
    end
  endtask

  task automatic test_reset_mid();
    xfer(32'h30, 1'b1, 4'hF, 32'h0BADC0DE);
    drain();
    hold = 1'b1;
    xfer(32'h30, 1'b0, 4'hF, 32'h0);
    xfer(32'h34, 1'b0, 4'hF, 32'h0);
    #3;
    rst = 1'b1; hold = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (gnt !== 1'b1 || rvalid !== 1'b0 || rvalidpar !== 1'b1) begin
      failures++; $display("FAIL reset_mid gnt=%b rvalid=%b rvalidpar=%b required=1/0/1",
                           gnt, rvalid, rvalidpar);
    end
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    xfer(32'h30, 1'b0, 4'hF, 32'h0);
    drain();
    checks++;
    if (last_rdata !== 32'h0BADC0DE) begin
      failures++; $display("FAIL reset_keeps_sram got=%h required=0badc0de", last_rdata);
    end
  endtask

  task automatic test_random();
    logic prev_bad = 1'b0;
    logic cur_bad;
    logic exp_mreq;
    for (int n = 0; n < 400; n++) begin
      checks++;
      if (gnt !== (exp_q.size() < MAXO)) begin
        failures++; $display("FAIL rand_gnt got=%b outstanding=%0d", gnt, exp_q.size());
      end
      hold = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 70) begin
        set_req(($urandom_range(0, 99) < 10) ? 32'(4 * MW) + 32'($urandom_range(0, 255) * 4)
                                             : 32'($urandom_range(0, 15) * 4),
                1'($urandom), 4'($urandom), $urandom,
                ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 5));
      end else begin
        req = 1'b0; reqpar = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (reqpar_err !== (reqpar === req)) begin
        failures++; $display("FAIL rand_reqpar got=%b req=%b reqpar=%b", reqpar_err, req, reqpar);
      end
      checks++;
      if (achk_err !== prev_bad) begin
        failures++; $display("FAIL rand_achk_err got=%b required=%b", achk_err, prev_bad);
      end
      cur_bad  = 1'b0;
      exp_mreq = 1'b0;
      if (req === 1'b1 && gnt === 1'b1) begin
        cur_bad = (achk !== model_achk(addr, we, be, wdata, prot, memtype, dbg));
        record_accept();
        exp_mreq = !last_acc_err;
      end
      prev_bad = cur_bad;
      checks++;
      if (mem_req !== exp_mreq) begin
        failures++; $display("FAIL rand_mem_req got=%b required=%b addr=%h", mem_req, exp_mreq, addr);
      end
      @(posedge clk); #1;
    end
    req = 1'b0; reqpar = 1'b1;
    drain();
  endtask

  initial begin
    rst = 1'b1; tb_clear = 1'b1; hold = 1'b0;
    req = 1'b0; reqpar = 1'b1; addr = '0; we = 1'b0; be = '0; wdata = '0;
    prot = '0; memtype = '0; dbg = 1'b0; achk = '0;
    last_rdata = '0; last_err = 1'b0; last_rchk = '0; last_acc_err = 1'b0;
    for (int i = 0; i < MW; i++) model_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_achk_err();
    test_reqpar();
    test_addr_range();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
